// File: rtl/m68k_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// m68k_bus_arbiter_if
//
// Groups the 68K bus arbitration pins, the sequencer handshake and the
// status/statistics outputs of m68k_bus_arbiter.
//
// Signals:
//   br_n          external bus request (async, active-low)
//   bgack_n       external bus grant acknowledge (async, active-low)
//   cyc_active    sequencer is in S1..S7 of its own cycle
//   bg_n          bus grant (registered, active-low)
//   drv_en        sequencer may drive control/address/data buses
//   cyc_allow     sequencer may leave S0
//   ext_owned     an external master holds the bus
//   arb_state     current arbiter state code
//   grant_count   number of grants taken by external masters (stats)
//   timeout_count number of BG timeouts (stats)
//
// Modports:
//   master  the arbiter side (drives grant, enables and status)
//   slave   the bus / sequencer side (drives requests and cyc_active)
//
// Handshake: the sequencer starts a cycle only while cyc_allow=1 and keeps
// cyc_active=1 until it is back in S0. bg_n=0 is only ever issued while
// cyc_active=0; an external master answers with bgack_n=0 and holds it for
// its whole tenure.
// ---------------------------------------------------------------------------
interface m68k_bus_arbiter_if;
    logic        br_n;
    logic        bgack_n;
    logic        cyc_active;
    logic        bg_n;
    logic        drv_en;
    logic        cyc_allow;
    logic        ext_owned;
    logic [2:0]  arb_state;
    logic [15:0] grant_count;
    logic [15:0] timeout_count;

    modport master (
        input  br_n, bgack_n, cyc_active,
        output bg_n, drv_en, cyc_allow, ext_owned, arb_state,
               grant_count, timeout_count
    );

    modport slave (
        output br_n, bgack_n, cyc_active,
        input  bg_n, drv_en, cyc_allow, ext_owned, arb_state,
               grant_count, timeout_count
    );
endinterface

// File: rtl/m68k_bus_arbiter.sv
// ---------------------------------------------------------------------------
// m68k_bus_arbiter
//
// Arbitrates the Atari ST 68K bus between the S0..S7 bus-cycle sequencer and
// external DMA masters (Blitter, DMA chip). Runs the BR/BG/BGACK handshake,
// tells the sequencer when it may start a cycle and gates its bus drivers.
//
// Ports:
//   clk    68K bus clock (C8M), all logic on posedge
//   s0rst  asynchronous, active-high reset
//   bus    m68k_bus_arbiter_if.master (see interface header for signals)
//
// Parameters:
//   SYNC_STAGES   synchroniser depth on br_n / bgack_n (>= 2)
//   BG_TIMEOUT    clocks BG may stay asserted without BGACK (>= 2)
//   RECLAIM_CLKS  idle clocks after BGACK release before drivers return (>= 1)
//
// Build option:
//   ARB_STATS_EN  when defined, grant_count / timeout_count are 16-bit
//                 saturating counters; otherwise both read 0.
//
// States (arb_state): OWN=0 DRAIN=1 GRANT=2 EXT=3 RECLAIM=4, 5..7 -> OWN.
// ---------------------------------------------------------------------------
module m68k_bus_arbiter #(
    parameter int SYNC_STAGES  = 2,
    parameter int BG_TIMEOUT   = 16,
    parameter int RECLAIM_CLKS = 2
) (
    input  logic                 clk,
    input  logic                 s0rst,
    m68k_bus_arbiter_if.master   bus
);

    localparam int GW = (BG_TIMEOUT   > 1) ? $clog2(BG_TIMEOUT)   : 1;
    localparam int RW = (RECLAIM_CLKS > 1) ? $clog2(RECLAIM_CLKS) : 1;

    typedef enum logic [2:0] {
        ST_OWN     = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_GRANT   = 3'd2,
        ST_EXT     = 3'd3,
        ST_RECLAIM = 3'd4
    } arb_state_e;

    // Synchronisers: shift in at bit 0, use the top bit. Reset to 1 so an
    // idle (deasserted) bus is seen straight out of reset.
    logic [SYNC_STAGES-1:0] br_sync_q, br_sync_d;
    logic [SYNC_STAGES-1:0] bgack_sync_q, bgack_sync_d;
    logic                   br_s, bgack_s;

    arb_state_e    state_q, state_d;
    logic [GW-1:0] gnt_tmr_q, gnt_tmr_d;
    logic [RW-1:0] rcl_tmr_q, rcl_tmr_d;
    logic          bg_n_q, bg_n_d;
    logic          timeout_hit;
    logic          cyc_allow;

    always_comb begin
        br_sync_d    = {br_sync_q[SYNC_STAGES-2:0], bus.br_n};
        bgack_sync_d = {bgack_sync_q[SYNC_STAGES-2:0], bus.bgack_n};
    end

    assign br_s    = ~br_sync_q[SYNC_STAGES-1];
    assign bgack_s = ~bgack_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        gnt_tmr_d   = '0;
        rcl_tmr_d   = '0;
        timeout_hit = 1'b0;
        cyc_allow   = 1'b0;
        case (state_q)
            ST_OWN: begin
                // Combinational so the sequencer cannot start a cycle on the
                // very clock a request is first seen.
                cyc_allow = ~br_s;
                if (br_s) state_d = bus.cyc_active ? ST_DRAIN : ST_GRANT;
            end
            ST_DRAIN: begin
                // Cycle ending wins over a withdrawn request.
                if (!bus.cyc_active) state_d = ST_GRANT;
                else if (!br_s)      state_d = ST_OWN;
            end
            ST_GRANT: begin
                gnt_tmr_d = gnt_tmr_q + 1'b1;
                // BGACK beats both the withdrawn-request and timeout exits.
                if (bgack_s)    state_d = ST_EXT;
                else if (!br_s) state_d = ST_RECLAIM;
                else if (gnt_tmr_q == GW'(BG_TIMEOUT - 1)) begin
                    state_d     = ST_RECLAIM;
                    timeout_hit = 1'b1;
                end
            end
            ST_EXT: begin
                // A still-pending request chains straight into a new grant.
                if (!bgack_s) state_d = br_s ? ST_GRANT : ST_RECLAIM;
            end
            ST_RECLAIM: begin
                rcl_tmr_d = rcl_tmr_q + 1'b1;
                if (br_s)                                     state_d = ST_GRANT;
                else if (rcl_tmr_q == RW'(RECLAIM_CLKS - 1)) state_d = ST_OWN;
            end
            default: state_d = ST_OWN;
        endcase
        // Timers restart on every state entry.
        if (state_d != state_q) begin
            gnt_tmr_d = '0;
            rcl_tmr_d = '0;
        end
        // BG is a registered copy of "next state is GRANT", so it drops on
        // entry to GRANT and releases on the clock BGACK is seen.
        bg_n_d = (state_d != ST_GRANT);
    end

    always_ff @(posedge clk or posedge s0rst) begin
        if (s0rst) begin
            br_sync_q    <= '1;
            bgack_sync_q <= '1;
            state_q      <= ST_OWN;
            gnt_tmr_q    <= '0;
            rcl_tmr_q    <= '0;
            bg_n_q       <= 1'b1;
        end else begin
            br_sync_q    <= br_sync_d;
            bgack_sync_q <= bgack_sync_d;
            state_q      <= state_d;
            gnt_tmr_q    <= gnt_tmr_d;
            rcl_tmr_q    <= rcl_tmr_d;
            bg_n_q       <= bg_n_d;
        end
    end

    assign bus.bg_n      = bg_n_q;
    assign bus.drv_en    = (state_q != ST_EXT) && (state_q != ST_RECLAIM);
    assign bus.ext_owned = (state_q == ST_EXT);
    assign bus.cyc_allow = cyc_allow;
    assign bus.arb_state = state_q;

`ifdef ARB_STATS_EN
    logic [15:0] grant_count_q, grant_count_d;
    logic [15:0] timeout_count_q, timeout_count_d;

    always_comb begin
        grant_count_d   = grant_count_q;
        timeout_count_d = timeout_count_q;
        if (state_d == ST_EXT && state_q != ST_EXT && grant_count_q != 16'hFFFF)
            grant_count_d = grant_count_q + 16'd1;
        if (timeout_hit && timeout_count_q != 16'hFFFF)
            timeout_count_d = timeout_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge s0rst) begin
        if (s0rst) begin
            grant_count_q   <= '0;
            timeout_count_q <= '0;
        end else begin
            grant_count_q   <= grant_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign bus.grant_count   = grant_count_q;
    assign bus.timeout_count = timeout_count_q;
`else
    logic unused_timeout_hit;
    assign unused_timeout_hit = timeout_hit;
    assign bus.grant_count    = 16'd0;
    assign bus.timeout_count  = 16'd0;
`endif

endmodule
